serv_exec_seq: RTL and testbench

//  Per-instruction sequencer for the bit/nibble-serial core. Fetches over ibus, strobes the

---
 rtl/serv_exec_seq_pkg.sv | 24 ++
 rtl/serv_exec_seq_cnt.sv | 33 +++
 rtl/serv_exec_seq.sv | 115 +++++++++++
 tb/tb_serv_exec_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_exec_seq_pkg.sv
// Shared definitions for the per-instruction sequencer: state encodings,
// counter width and the decoded-flag bundle consumed by the FSM.
package serv_exec_seq_pkg;

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned STATE_W = 3;

  // Kept as plain constants so the encoding matches the legacy header values
  localparam logic [STATE_W-1:0] S_RST   = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] S_RF    = 3'd2;
  localparam logic [STATE_W-1:0] S_INIT  = 3'd3;
  localparam logic [STATE_W-1:0] S_WAIT  = 3'd4;
  localparam logic [STATE_W-1:0] S_RUN   = 3'd5;

  // Decoder control outputs the sequencer reacts to
  typedef struct packed {
    logic two_stage;
    logic dbus;
    logic shift;
    logic mdu;
  } dec_flags_t;

endpackage

// File: rtl/serv_exec_seq_cnt.sv
// Serial bit-index counter: advances by W per enabled cycle, wraps mod 32.
// Ports: clk, i_rst_n (async active-low), i_en (step), o_cnt (bit index),
//        o_done (index is the last step of a pass, 32-W).
module serv_exec_seq_cnt
  import serv_exec_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(32 - W);

  logic [CNT_W-1:0] r_cnt;

  // Natural 5-bit overflow returns the index to 0 after the last step
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + STEP;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/serv_exec_seq.sv
// Per-instruction sequencer for the bit/nibble-serial core: fetch, RF read
// request, optional INIT pass, stall for dbus/MDU/shifter, RUN pass.
// Ports: clk, i_rst_n; ibus (o_ibus_cyc/i_ibus_ack, o_decode_en);
//        decoded flags (i_two_stage_op, i_dbus_en, i_shift_op, i_mdu_op);
//        RF (o_rf_rreq/i_rf_ready); serial control (o_init, o_cnt_en, o_cnt,
//        o_cnt_done, o_pc_en); stall handshakes (o_dbus_cyc/i_dbus_ack,
//        o_mdu_valid/i_mdu_ready, i_sh_done).
module serv_exec_seq
  import serv_exec_seq_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned MDU = 0
) (
  input  logic       clk,
  input  logic       i_rst_n,
  output logic       o_ibus_cyc,
  input  logic       i_ibus_ack,
  output logic       o_decode_en,
  input  logic       i_two_stage_op,
  input  logic       i_dbus_en,
  input  logic       i_shift_op,
  input  logic       i_mdu_op,
  output logic       o_rf_rreq,
  input  logic       i_rf_ready,
  output logic       o_init,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  output logic       o_mdu_valid,
  input  logic       i_mdu_ready,
  input  logic       i_sh_done,
  output logic       o_pc_en
);

  localparam logic MDU_EN = (MDU != 0);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               r_rf_first;
  dec_flags_t         w_dec;
  logic               w_mdu_wait;
  logic               w_dbus_wait;
  logic               w_sh_wait;
  logic               w_cnt_en;
  logic               w_cnt_done;
  logic [CNT_W-1:0]   w_cnt;

  assign w_dec = '{two_stage: i_two_stage_op, dbus: i_dbus_en,
                   shift: i_shift_op, mdu: i_mdu_op};

  // Stall source selection: mdu > dbus > shift
  assign w_mdu_wait  = MDU_EN & w_dec.mdu;
  assign w_dbus_wait = w_dec.dbus & ~w_mdu_wait;
  assign w_sh_wait   = w_dec.shift & ~w_mdu_wait & ~w_dec.dbus;

  assign w_cnt_en = (r_state == S_INIT) | (r_state == S_RUN);

  serv_exec_seq_cnt #(.W(W)) u_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_cnt_en),
    .o_cnt   (w_cnt),
    .o_done  (w_cnt_done)
  );

  // State register; r_rf_first marks the cycle right after the fetch ack
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RST;
      r_rf_first <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rf_first <= (r_state == S_FETCH) & i_ibus_ack;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: if (i_ibus_ack) w_next = S_RF;
      S_RF:    if (i_rf_ready) w_next = w_dec.two_stage ? S_INIT : S_RUN;
      S_INIT:  if (w_cnt_done) w_next = S_WAIT;
      S_WAIT: begin
        if (w_mdu_wait) begin
          if (i_mdu_ready) w_next = S_RUN;
        end else if (w_dbus_wait) begin
          if (i_dbus_ack) w_next = S_RUN;
        end else if (w_sh_wait) begin
          if (i_sh_done) w_next = S_RUN;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN:   if (w_cnt_done) w_next = S_FETCH;
      default: w_next = S_RST;
    endcase
  end

  // Outputs decode the reset-cleared state so they all drop with reset
  assign o_ibus_cyc  = (r_state == S_FETCH);
  assign o_decode_en = (r_state == S_FETCH) & i_ibus_ack;
  assign o_rf_rreq   = r_rf_first;
  assign o_init      = (r_state == S_INIT);
  assign o_cnt_en    = w_cnt_en;
  assign o_cnt       = w_cnt;
  assign o_cnt_done  = w_cnt_en & w_cnt_done;
  assign o_dbus_cyc  = (r_state == S_WAIT) & w_dbus_wait;
  assign o_mdu_valid = (r_state == S_WAIT) & w_mdu_wait;
  assign o_pc_en     = (r_state == S_RUN);

endmodule

// File: tb/tb_serv_exec_seq.sv
// Testbench for serv_exec_seq: two instances (W=4/MDU=1 and W=1/MDU=0) share
// stimulus while the idle one is held in reset. Each instruction is described
// as a transaction (flags + latencies); the bench expands it into a per-cycle
// table of stimulus and expected outputs and replays it against the DUT.
module tb_serv_exec_seq;

  typedef struct packed {
    logic ibus_ack, rf_ready, dbus_ack, mdu_ready, sh_done;
    logic two, dbus, shift, mdu;
  } stim_t;

  typedef struct packed {
    logic       ibus_cyc, decode_en, rf_rreq, init, cnt_en;
    logic [4:0] cnt;
    logic       cnt_done, dbus_cyc, mdu_valid, pc_en;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic ibus_ack, two_stage, dbus_en, shift_op, mdu_op;
  logic rf_ready, dbus_ack, mdu_ready, sh_done;

  logic       a_ibus_cyc, a_decode_en, a_rf_rreq, a_init, a_cnt_en, a_cnt_done;
  logic       a_dbus_cyc, a_mdu_valid, a_pc_en;
  logic [4:0] a_cnt;
  logic       b_ibus_cyc, b_decode_en, b_rf_rreq, b_init, b_cnt_en, b_cnt_done;
  logic       b_dbus_cyc, b_mdu_valid, b_pc_en;
  logic [4:0] b_cnt;

  serv_exec_seq #(.W(4), .MDU(1)) u_dut_a (
    .clk(clk), .i_rst_n(rst_a),
    .o_ibus_cyc(a_ibus_cyc), .i_ibus_ack(ibus_ack), .o_decode_en(a_decode_en),
    .i_two_stage_op(two_stage), .i_dbus_en(dbus_en), .i_shift_op(shift_op),
    .i_mdu_op(mdu_op), .o_rf_rreq(a_rf_rreq), .i_rf_ready(rf_ready),
    .o_init(a_init), .o_cnt_en(a_cnt_en), .o_cnt(a_cnt), .o_cnt_done(a_cnt_done),
    .o_dbus_cyc(a_dbus_cyc), .i_dbus_ack(dbus_ack), .o_mdu_valid(a_mdu_valid),
    .i_mdu_ready(mdu_ready), .i_sh_done(sh_done), .o_pc_en(a_pc_en)
  );

  serv_exec_seq #(.W(1), .MDU(0)) u_dut_b (
    .clk(clk), .i_rst_n(rst_b),
    .o_ibus_cyc(b_ibus_cyc), .i_ibus_ack(ibus_ack), .o_decode_en(b_decode_en),
    .i_two_stage_op(two_stage), .i_dbus_en(dbus_en), .i_shift_op(shift_op),
    .i_mdu_op(mdu_op), .o_rf_rreq(b_rf_rreq), .i_rf_ready(rf_ready),
    .o_init(b_init), .o_cnt_en(b_cnt_en), .o_cnt(b_cnt), .o_cnt_done(b_cnt_done),
    .o_dbus_cyc(b_dbus_cyc), .i_dbus_ack(dbus_ack), .o_mdu_valid(b_mdu_valid),
    .i_mdu_ready(mdu_ready), .i_sh_done(sh_done), .o_pc_en(b_pc_en)
  );

  obs_t act_a, act_b;
  assign act_a = {a_ibus_cyc, a_decode_en, a_rf_rreq, a_init, a_cnt_en, a_cnt,
                  a_cnt_done, a_dbus_cyc, a_mdu_valid, a_pc_en};
  assign act_b = {b_ibus_cyc, b_decode_en, b_rf_rreq, b_init, b_cnt_en, b_cnt,
                  b_cnt_done, b_dbus_cyc, b_mdu_valid, b_pc_en};

  int n_cmp = 0;
  int n_err = 0;

  stim_t q_stim[$];
  obs_t  q_exp[$];
  string q_tag[$];

  function automatic stim_t rnd_stim();
    logic [8:0] v;
    v = 9'($urandom);
    rnd_stim = v;
  endfunction

  function automatic obs_t only_fetch();
    obs_t e;
    e = '0;
    e.ibus_cyc = 1'b1;
    only_fetch = e;
  endfunction

  task automatic drive(input stim_t s);
    {ibus_ack, rf_ready, dbus_ack, mdu_ready, sh_done,
     two_stage, dbus_en, shift_op, mdu_op} = s;
  endtask

  // Expand one instruction into per-cycle stimulus/expectation tables.
  // d_f/d_r/d_w: cycles before ibus_ack / rf_ready / stall release.
  // run_len: RUN cycles to include (full pass = 32/W).
  task automatic build_instr(input bit sel, input bit f_two, input bit f_dbus,
                             input bit f_shift, input bit f_mdu, input int d_f,
                             input int d_r, input int d_w, input int run_len);
    int    np, w, mode;
    stim_t s;
    obs_t  e;
    np = sel ? 32 : 8;
    w  = sel ? 1 : 4;
    // stall source: 0 none, 1 mdu, 2 dbus, 3 shift
    if (!sel && f_mdu) mode = 1;
    else if (f_dbus)   mode = 2;
    else if (f_shift)  mode = 3;
    else               mode = 0;
    q_stim.delete(); q_exp.delete(); q_tag.delete();
    for (int k = 0; k <= d_f; k++) begin
      s = rnd_stim();
      s.ibus_ack = (k == d_f);
      e = only_fetch();
      e.decode_en = (k == d_f);
      q_stim.push_back(s); q_exp.push_back(e); q_tag.push_back("fetch");
    end
    for (int k = 0; k <= d_r; k++) begin
      s = rnd_stim();
      {s.two, s.dbus, s.shift, s.mdu} = {f_two, f_dbus, f_shift, f_mdu};
      s.rf_ready = (k == d_r);
      e = '0;
      e.rf_rreq = (k == 0);
      q_stim.push_back(s); q_exp.push_back(e); q_tag.push_back("rf");
    end
    if (f_two) begin
      for (int k = 0; k < np; k++) begin
        s = rnd_stim();
        {s.two, s.dbus, s.shift, s.mdu} = {f_two, f_dbus, f_shift, f_mdu};
        e = '0;
        e.init = 1'b1; e.cnt_en = 1'b1; e.cnt = 5'(k * w);
        e.cnt_done = (k == np - 1);
        q_stim.push_back(s); q_exp.push_back(e); q_tag.push_back("init");
      end
      for (int k = 0; k <= ((mode == 0) ? 0 : d_w); k++) begin
        s = rnd_stim();
        {s.two, s.dbus, s.shift, s.mdu} = {f_two, f_dbus, f_shift, f_mdu};
        if (mode == 1) s.mdu_ready = (k == d_w);
        if (mode == 2) s.dbus_ack  = (k == d_w);
        if (mode == 3) s.sh_done   = (k == d_w);
        e = '0;
        e.mdu_valid = (mode == 1);
        e.dbus_cyc  = (mode == 2);
        q_stim.push_back(s); q_exp.push_back(e); q_tag.push_back("wait");
      end
    end
    for (int k = 0; k < run_len; k++) begin
      s = rnd_stim();
      {s.two, s.dbus, s.shift, s.mdu} = {f_two, f_dbus, f_shift, f_mdu};
      e = '0;
      e.cnt_en = 1'b1; e.pc_en = 1'b1; e.cnt = 5'(k * w);
      e.cnt_done = (k == np - 1);
      q_stim.push_back(s); q_exp.push_back(e); q_tag.push_back("run");
    end
  endtask

  // Replay the tables: drive after posedge, sample on negedge.
  // Ends at posedge+1 with all inputs cleared.
  task automatic play(input bit sel, input string name);
    obs_t act;
    for (int i = 0; i < q_stim.size(); i++) begin
      drive(q_stim[i]);
      @(negedge clk);
      act = sel ? act_b : act_a;
      n_cmp++;
      if (act !== q_exp[i]) begin
        n_err++;
        $display("FAIL %s cyc%0d(%s): got %h want %h", name, i, q_tag[i], act, q_exp[i]);
      end
      @(posedge clk); #1;
    end
    drive('0);
  endtask

  task automatic test_reset(input bit sel);
    obs_t act;
    drive('0);
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    #1;
    act = sel ? act_b : act_a;
    n_cmp++;
    if (act !== obs_t'(0)) begin
      n_err++; $display("FAIL reset_hold: got %h want 0", act);
    end
    @(posedge clk); #1;
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    @(negedge clk);
    act = sel ? act_b : act_a;
    n_cmp++;
    if (act !== obs_t'(0)) begin
      n_err++; $display("FAIL reset_first_cycle: got %h want 0", act);
    end
    @(posedge clk); #1;
    @(negedge clk);
    act = sel ? act_b : act_a;
    n_cmp++;
    if (act !== only_fetch()) begin
      n_err++; $display("FAIL reset_to_fetch: got %h want %h", act, only_fetch());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    build_instr(0, 0, 0, 0, 0, 0, 1, 0, 8);
    play(0, "add");
  endtask

  task automatic test_load();
    build_instr(0, 1, 1, 0, 0, 1, 0, 2, 8);
    play(0, "load");
  endtask

  task automatic test_mdu();
    build_instr(0, 1, 0, 0, 1, 0, 0, 5, 8);
    play(0, "mdu_a");
  endtask

  task automatic test_shift();
    build_instr(0, 1, 0, 1, 0, 0, 2, 10, 8);
    play(0, "shift");
  endtask

  task automatic test_priority();
    build_instr(0, 1, 1, 1, 1, 0, 0, 3, 8);
    play(0, "prio_mdu");
    build_instr(0, 1, 1, 1, 0, 2, 1, 4, 8);
    play(0, "prio_dbus");
  endtask

  task automatic test_back_to_back(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      build_instr(sel, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 6)), sel ? 32 : 8);
      play(sel, "random");
    end
  endtask

  task automatic test_midpass_reset();
    obs_t e;
    build_instr(0, 0, 0, 0, 0, 0, 0, 0, 3);
    play(0, "pre_reset");
    e = '0;
    e.cnt_en = 1'b1; e.pc_en = 1'b1; e.cnt = 5'd12;
    n_cmp++;
    if (act_a !== e) begin
      n_err++; $display("FAIL midpass_cnt12: got %h want %h", act_a, e);
    end
    rst_a = 1'b0;
    #1;
    n_cmp++;
    if (act_a !== obs_t'(0)) begin
      n_err++; $display("FAIL midpass_async_clear: got %h want 0", act_a);
    end
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (act_a !== obs_t'(0)) begin
      n_err++; $display("FAIL midpass_rst_cycle: got %h want 0", act_a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (act_a !== only_fetch()) begin
      n_err++; $display("FAIL midpass_refetch: got %h want %h", act_a, only_fetch());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious();
    drive('0);
    dbus_ack = 1'b1; mdu_ready = 1'b1; sh_done = 1'b1; rf_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (act_a !== only_fetch()) begin
        n_err++; $display("FAIL spurious_fetch%0d: got %h want %h", k, act_a, only_fetch());
      end
      @(posedge clk); #1;
    end
    drive('0);
    build_instr(0, 0, 0, 0, 0, 0, 0, 0, 8);
    play(0, "after_spurious");
  endtask

  task automatic test_w1();
    build_instr(1, 0, 0, 0, 0, 1, 1, 0, 32);
    play(1, "w1_add");
    build_instr(1, 1, 0, 0, 1, 0, 0, 5, 32);
    play(1, "w1_mdu_off");
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    test_reset(0);
    test_add();
    test_load();
    test_mdu();
    test_shift();
    test_priority();
    test_spurious();
    test_back_to_back(0, 30);
    test_midpass_reset();
    rst_a = 1'b0;
    test_reset(1);
    test_w1();
    test_back_to_back(1, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
